// File: rtl/spi_apb_sequencer.sv
// APB master that sequences spictrl register traffic (mode config, TX push,
// event polling, RX pop, LST) on behalf of a valid/ready streaming client.
module spi_apb_sequencer #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter logic [31:0] MODE_WORD    = 32'h030B_0000,
    parameter int unsigned MAX_INFLIGHT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        err,
    input  logic [31:0] tx_data,
    input  logic        tx_valid,
    input  logic        tx_last,
    output logic        tx_ready,
    output logic [31:0] rx_data,
    output logic        rx_valid,
    output logic        rx_last,
    input  logic        rx_ready,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        pready
);
    localparam int unsigned   IW       = $clog2(MAX_INFLIGHT + 1);
    localparam logic [IW-1:0] MAX_CNT  = IW'(MAX_INFLIGHT);
    localparam logic [IW-1:0] ONE_CNT  = IW'(1);
    localparam logic [31:0]   OFF_MODE = 32'h0000_0020;
    localparam logic [31:0]   OFF_EVT  = 32'h0000_0024;
    localparam logic [31:0]   OFF_CTRL = 32'h0000_002C;
    localparam logic [31:0]   OFF_TX   = 32'h0000_0030;
    localparam logic [31:0]   OFF_RX   = 32'h0000_0034;
    localparam logic [31:0]   LST_WORD = 32'h0040_0000;

    typedef enum logic [2:0] {
        IDLE,
        CFG,
        POLL,
        TXW,
        RXR,
        LST,
        DRAIN,
        FIN
    } state_t;

    state_t        r_state;
    logic [IW-1:0] r_inflight;
    logic          r_lastSeen;
    logic          r_lstSent;
    logic          r_txLast;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic          r_txReady;
    logic [31:0]   r_rxData;
    logic          r_rxValid;
    logic          r_rxLast;
    logic          r_psel;
    logic          r_penable;
    logic          r_pwrite;
    logic [31:0]   r_paddr;
    logic [31:0]   r_pwdata;

    state_t        w_pollNext;
    state_t        w_afterState;
    state_t        w_launchState;
    logic [31:0]   w_setupAddr;
    logic [31:0]   w_setupData;
    logic          w_setupWrite;
    logic          w_accessDone;

    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;
    assign tx_ready = r_txReady;
    assign rx_data  = r_rxData;
    assign rx_valid = r_rxValid;
    assign rx_last  = r_rxLast;
    assign psel     = r_psel;
    assign penable  = r_penable;
    assign pwrite   = r_pwrite;
    assign paddr    = r_paddr;
    assign pwdata   = r_pwdata;

    assign w_accessDone = r_psel && r_penable && pready;

    // Event-register decision: draining RX outranks pushing TX so the FIFO never backs up.
    always_comb begin
        w_pollNext = POLL;
        if (prdata[9] && !r_rxValid && (r_inflight != '0)) begin
            w_pollNext = RXR;
        end else if (tx_valid && !r_lastSeen && prdata[8] && (r_inflight < MAX_CNT)) begin
            w_pollNext = TXW;
        end else if (r_lastSeen && !r_lstSent) begin
            w_pollNext = LST;
        end else if (r_lastSeen && (r_inflight == '0) && !r_rxValid) begin
            w_pollNext = FIN;
        end
    end

    always_comb begin
        w_afterState  = (r_state == POLL) ? w_pollNext : POLL;
        w_launchState = (r_state == IDLE) ? CFG : w_afterState;
    end

    // Address/data for the SETUP cycle of whichever access is launched next.
    always_comb begin
        w_setupAddr  = BASE_ADDR + OFF_EVT;
        w_setupData  = '0;
        w_setupWrite = 1'b0;
        case (w_launchState)
            CFG: begin
                w_setupAddr  = BASE_ADDR + OFF_MODE;
                w_setupData  = MODE_WORD;
                w_setupWrite = 1'b1;
            end
            TXW: begin
                w_setupAddr  = BASE_ADDR + OFF_TX;
                w_setupData  = tx_data;
                w_setupWrite = 1'b1;
            end
            RXR: begin
                w_setupAddr  = BASE_ADDR + OFF_RX;
            end
            LST: begin
                w_setupAddr  = BASE_ADDR + OFF_CTRL;
                w_setupData  = LST_WORD;
                w_setupWrite = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_inflight <= '0;
            r_lastSeen <= 1'b0;
            r_lstSent  <= 1'b0;
            r_txLast   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_txReady  <= 1'b0;
            r_rxData   <= '0;
            r_rxValid  <= 1'b0;
            r_rxLast   <= 1'b0;
            r_psel     <= 1'b0;
            r_penable  <= 1'b0;
            r_pwrite   <= 1'b0;
            r_paddr    <= '0;
            r_pwdata   <= '0;
        end else begin
            r_txReady <= 1'b0;
            r_done    <= 1'b0;
            if (r_rxValid && rx_ready) begin
                r_rxValid <= 1'b0;
                r_rxLast  <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    // The done cycle itself still reads as IDLE, so a start there is dropped.
                    if (start && !r_done) begin
                        r_state    <= CFG;
                        r_busy     <= 1'b1;
                        r_err      <= 1'b0;
                        r_inflight <= '0;
                        r_lastSeen <= 1'b0;
                        r_lstSent  <= 1'b0;
                        r_psel     <= 1'b1;
                        r_penable  <= 1'b0;
                        r_pwrite   <= w_setupWrite;
                        r_paddr    <= w_setupAddr;
                        r_pwdata   <= w_setupData;
                    end
                end
                CFG, POLL, TXW, RXR, LST: begin
                    if (r_psel && !r_penable) begin
                        r_penable <= 1'b1;
                    end else if (w_accessDone) begin
                        case (r_state)
                            POLL: begin
                                if (prdata[12]) begin
                                    r_err <= 1'b1;
                                end
                            end
                            TXW: begin
                                r_txReady  <= 1'b1;
                                r_inflight <= r_inflight + ONE_CNT;
                                r_lastSeen <= r_lastSeen | r_txLast;
                            end
                            RXR: begin
                                r_rxData   <= prdata;
                                r_rxValid  <= 1'b1;
                                r_rxLast   <= r_lastSeen && r_lstSent && (r_inflight == ONE_CNT);
                                r_inflight <= r_inflight - ONE_CNT;
                            end
                            LST: begin
                                r_lstSent <= 1'b1;
                            end
                            default: begin
                            end
                        endcase
                        r_state <= w_afterState;
                        if (w_afterState == FIN) begin
                            r_psel    <= 1'b0;
                            r_penable <= 1'b0;
                        end else begin
                            r_psel    <= 1'b1;
                            r_penable <= 1'b0;
                            r_pwrite  <= w_setupWrite;
                            r_paddr   <= w_setupAddr;
                            r_pwdata  <= w_setupData;
                            r_txLast  <= tx_last;
                        end
                    end
                end
                FIN: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    // DRAIN is never entered; recover cleanly if it ever is.
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_apb_sequencer.sv
// Bench for spi_apb_sequencer: an APB spictrl loopback model with a serial
// shift latency, a streaming client, and table-driven burst scenarios.
module tb_spi_apb_sequencer;
    localparam logic [31:0] BASE       = 32'h0000_0000;
    localparam logic [31:0] MODE       = 32'h030B_0000;
    localparam int          LAT        = 24;
    localparam int          FIFO_DEPTH = 16;
    localparam int          MAXI       = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, err;
    logic [31:0] tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        tx_last = 1'b0;
    logic        tx_ready;
    logic [31:0] rx_data;
    logic        rx_valid, rx_last;
    logic        rx_ready = 1'b1;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [31:0] prdata = '0;
    logic        pready = 1'b1;

    always #5 clk = ~clk;

    spi_apb_sequencer #(
        .BASE_ADDR(BASE),
        .MODE_WORD(MODE),
        .MAX_INFLIGHT(MAXI)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_last(rx_last), .rx_ready(rx_ready),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .pready(pready)
    );

    typedef struct {
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
    } op_t;

    typedef struct {
        int nWords;
        int waitMax;
        int stallLen;
        bit injOvr;
        int expTx;
        int expRx;
        bit expErr;
        bit expFull;
    } vec_t;

    typedef struct {
        int txCnt;
        int rxCnt;
        int orderErr;
        int lastErr;
        bit doneSeen;
        bit busyAtDone;
        bit doneLow;
        bit errAfterStart;
        bit busyAfterStart;
    } res_t;

    int          vecCount = 0;
    int          missCount = 0;
    int          waitMax = 0;
    bit          injOvr = 1'b0;
    int          waitLeft = 0;
    longint      cyc = 0;
    longint      lastAt = 0;
    logic [31:0] rxq[$];
    logic [31:0] pipeData[$];
    longint      pipeAt[$];
    op_t         opLog[$];
    int          modelInflight = 0;
    int          maxInflight = 0;
    int          rxWhileValid = 0;
    int          txWhileFull = 0;
    int          protoErr = 0;
    logic [31:0] setupAddr = '0;
    logic [31:0] setupData = '0;
    logic        setupWrite = 1'b0;

    // spictrl register view: NF while the shared FIFO has room, NE once a word has shifted back.
    function automatic logic [31:0] slaveRead(input logic [31:0] a);
        logic [31:0] v;
        v = '0;
        if (a == BASE + 32'h24) begin
            v[8]  = (pipeData.size() + rxq.size()) < FIFO_DEPTH;
            v[9]  = rxq.size() > 0;
            v[12] = injOvr;
        end else if (a == BASE + 32'h34 && rxq.size() > 0) begin
            v = rxq[0];
        end
        return v;
    endfunction

    always @(negedge clk) begin
        if (psel && !penable) begin
            waitLeft   = (waitMax > 0) ? int'($urandom_range(waitMax, 0)) : 0;
            setupAddr  = paddr;
            setupData  = pwdata;
            setupWrite = pwrite;
        end
        if (psel && penable) begin
            if (paddr !== setupAddr || pwrite !== setupWrite || pwdata !== setupData) protoErr++;
            pready = (waitLeft == 0);
            if (waitLeft > 0) waitLeft--;
            prdata = slaveRead(paddr);
        end else begin
            pready = 1'b1;
            prdata = '0;
        end
    end

    // Words shift out one after another, each taking LAT cycles, then land in the RX FIFO.
    always @(posedge clk) begin
        longint at;
        cyc++;
        if (!rst && psel && penable && pready) begin
            opLog.push_back('{pwrite, paddr, pwdata});
            if (pwrite && paddr == BASE + 32'h30) begin
                if (modelInflight >= MAXI) txWhileFull++;
                at = ((cyc > lastAt) ? cyc : lastAt) + LAT;
                pipeData.push_back(pwdata);
                pipeAt.push_back(at);
                lastAt = at;
                modelInflight++;
                if (modelInflight > maxInflight) maxInflight = modelInflight;
            end
            if (!pwrite && paddr == BASE + 32'h34) begin
                if (rx_valid) rxWhileValid++;
                if (rxq.size() > 0) void'(rxq.pop_front());
                modelInflight--;
            end
        end
        while (pipeAt.size() > 0 && pipeAt[0] <= cyc) begin
            rxq.push_back(pipeData.pop_front());
            void'(pipeAt.pop_front());
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic resetModel();
        rxq.delete();
        pipeData.delete();
        pipeAt.delete();
        opLog.delete();
        lastAt        = 0;
        modelInflight = 0;
        maxInflight   = 0;
        rxWhileValid  = 0;
        txWhileFull   = 0;
        protoErr      = 0;
    endtask

    task automatic applyStimulus(input int n, input int wm, input int stallLen, input bit ovr,
                                 input bit startOnDone, output res_t r);
        logic [31:0] words[$];
        int txIdx;
        int rxIdx;
        int cycles;
        r = '{0, 0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        txIdx = 0;
        rxIdx = 0;
        cycles = 0;
        for (int i = 0; i < n; i++) words.push_back($urandom);
        @(negedge clk);
        resetModel();
        waitMax  = wm;
        injOvr   = ovr;
        rx_ready = 1'b1;
        tx_valid = 1'b1;
        tx_data  = words[0];
        tx_last  = (n == 1);
        start    = 1'b1;
        while (!r.doneSeen && cycles < 20000) begin
            @(negedge clk);
            cycles++;
            start = (cycles == 10);
            if (cycles == 1) begin
                r.errAfterStart  = err;
                r.busyAfterStart = busy;
            end
            if (tx_ready) begin
                r.txCnt++;
                txIdx++;
            end
            tx_valid = (txIdx < n);
            tx_data  = (txIdx < n) ? words[txIdx] : 32'h0;
            tx_last  = (txIdx == n - 1);
            rx_ready = !(stallLen > 0 && cycles >= 60 && cycles < 60 + stallLen);
            if (rx_valid && rx_ready) begin
                if (rxIdx >= n || rx_data !== words[rxIdx]) r.orderErr++;
                if (rx_last !== (rxIdx == n - 1)) r.lastErr++;
                rxIdx++;
                r.rxCnt++;
            end
            if (done) begin
                r.doneSeen   = 1'b1;
                r.busyAtDone = busy;
                if (startOnDone) start = 1'b1;
            end
        end
        @(negedge clk);
        start     = 1'b0;
        r.doneLow = !done;
        rx_ready  = 1'b1;
    endtask

    task automatic checkBurst(input res_t r, input int expTx, input int expRx, input bit expErr,
                              input bit expFull);
        int w20 = 0, w2c = 0, w2cIdx = -1, lastW30 = -1, lastR34 = -1;
        logic [31:0] w2cData = '0;
        foreach (opLog[i]) begin
            if (opLog[i].w && opLog[i].a == BASE + 32'h20) w20++;
            if (opLog[i].w && opLog[i].a == BASE + 32'h30) lastW30 = i;
            if (!opLog[i].w && opLog[i].a == BASE + 32'h34) lastR34 = i;
            if (opLog[i].w && opLog[i].a == BASE + 32'h2C) begin
                w2c++;
                w2cIdx  = i;
                w2cData = opLog[i].d;
            end
        end
        checkOutput("doneSeen", 32'(r.doneSeen), 32'd1);
        checkOutput("txReadyPulses", 32'(r.txCnt), 32'(expTx));
        checkOutput("rxWords", 32'(r.rxCnt), 32'(expRx));
        checkOutput("rxOrder", 32'(r.orderErr), 32'd0);
        checkOutput("rxLastPlacement", 32'(r.lastErr), 32'd0);
        checkOutput("busyAtDone", 32'(r.busyAtDone), 32'd0);
        checkOutput("donePulseWidth", 32'(r.doneLow), 32'd1);
        checkOutput("errClearedByStart", 32'(r.errAfterStart), 32'd0);
        checkOutput("busyAfterStart", 32'(r.busyAfterStart), 32'd1);
        checkOutput("errAtEnd", 32'(err), 32'(expErr));
        checkOutput("cfgAddr", (opLog.size() > 0) ? opLog[0].a : 32'hFFFF_FFFF, BASE + 32'h20);
        checkOutput("cfgData", (opLog.size() > 0) ? opLog[0].d : 32'hFFFF_FFFF, MODE);
        checkOutput("cfgWrite", (opLog.size() > 0) ? 32'(opLog[0].w) : 32'hFF, 32'd1);
        checkOutput("firstPollAddr", (opLog.size() > 1) ? opLog[1].a : 32'hFFFF_FFFF, BASE + 32'h24);
        checkOutput("firstPollRead", (opLog.size() > 1) ? 32'(opLog[1].w) : 32'hFF, 32'd0);
        checkOutput("cfgCount", 32'(w20), 32'd1);
        checkOutput("lstCount", 32'(w2c), 32'd1);
        checkOutput("lstData", w2cData, 32'h0040_0000);
        checkOutput("lstOrder", 32'((lastW30 < w2cIdx) && (w2cIdx < lastR34)), 32'd1);
        checkOutput("inflightOverMax", 32'(maxInflight > MAXI), 32'd0);
        checkOutput("txWhileFull", 32'(txWhileFull), 32'd0);
        checkOutput("rxReadWhileValid", 32'(rxWhileValid), 32'd0);
        checkOutput("apbStable", 32'(protoErr), 32'd0);
        if (expFull) checkOutput("reachedMaxInflight", 32'(maxInflight), 32'(MAXI));
    endtask

    vec_t vecs[6];
    res_t res;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int idleBad;
        bit found;
        vecs[0] = '{1, 0, 0, 1'b0, 1, 1, 1'b0, 1'b0};
        vecs[1] = '{8, 3, 0, 1'b0, 8, 8, 1'b0, 1'b0};
        vecs[2] = '{5, 2, 0, 1'b1, 5, 5, 1'b1, 1'b0};
        vecs[3] = '{12, 3, 500, 1'b0, 12, 12, 1'b0, 1'b1};
        vecs[4] = '{12, 1, 0, 1'b0, 12, 12, 1'b0, 1'b0};
        vecs[5] = '{3, 0, 0, 1'b0, 3, 3, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetBusy", 32'(busy), 32'd0);
        checkOutput("resetDone", 32'(done), 32'd0);
        checkOutput("resetErr", 32'(err), 32'd0);
        checkOutput("resetPsel", 32'({psel, penable, pwrite}), 32'd0);
        checkOutput("resetPaddr", paddr, 32'd0);
        checkOutput("resetPwdata", pwdata, 32'd0);
        checkOutput("resetTxReady", 32'(tx_ready), 32'd0);
        checkOutput("resetRx", 32'({rx_valid, rx_last}), 32'd0);
        checkOutput("resetRxData", rx_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            $display("[TB] vector %0d: %0d words, waitMax %0d, stall %0d, ovr %0d",
                     v, vecs[v].nWords, vecs[v].waitMax, vecs[v].stallLen, vecs[v].injOvr);
            applyStimulus(vecs[v].nWords, vecs[v].waitMax, vecs[v].stallLen, vecs[v].injOvr, 1'b0, res);
            checkBurst(res, vecs[v].expTx, vecs[v].expRx, vecs[v].expErr, vecs[v].expFull);
            repeat (3) @(negedge clk);
        end

        // Overrun stays sticky in IDLE, and a start coinciding with done is dropped.
        applyStimulus(4, 2, 0, 1'b1, 1'b1, res);
        checkBurst(res, 4, 4, 1'b1, 1'b0);
        injOvr  = 1'b0;
        idleBad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy || psel) idleBad++;
        end
        checkOutput("startOnDoneIgnored", 32'(idleBad), 32'd0);
        checkOutput("errSticky", 32'(err), 32'd1);

        // Reset landing on a TX write ACCESS cycle.
        resetModel();
        waitMax  = 0;
        tx_valid = 1'b1;
        tx_data  = 32'hA5A5_0001;
        tx_last  = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (psel && penable && pwrite && paddr == BASE + 32'h30) found = 1'b1;
        end
        checkOutput("reachedTxAccess", 32'(found), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rstDropsPsel", 32'({psel, penable}), 32'd0);
        checkOutput("rstClearsBusy", 32'(busy), 32'd0);
        checkOutput("rstNoTxReady", 32'(tx_ready), 32'd0);
        checkOutput("rstClearsErr", 32'(err), 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        tx_valid = 1'b0;
        resetModel();
        repeat (2) @(negedge clk);
        applyStimulus(6, 2, 0, 1'b0, 1'b0, res);
        checkBurst(res, 6, 6, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/spi_apb_sequencer.md
Name: spi_apb_sequencer

Overview:
- APB master that drives the spictrl core (spi_wrap) register interface on behalf of a streaming client.
- Sits directly upstream of spi_wrap's APB slave port. Replaces software/BFM register traffic: configures the mode register, pushes TX words, polls the event register, pops RX words and raises LST at end of burst.
- Client side uses valid/ready streams for TX and RX words.

Parameters:
BASE_ADDR, 32'h0000_0000, spictrl APB base; register offsets are added to it
MODE_WORD, 32'h030B_0000, value written to mode reg (EN=1, MS=1, divider fields)
MAX_INFLIGHT, 8, max words written to TX minus words read from RX (must be ≤ spictrl FIFO depth)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse: begin config + transfer; ignored while busy
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at end of burst
err  out  1  sticky overrun flag (event bit 12 seen); cleared by accepted start
tx_data  in  32  word to transmit
tx_valid  in  1  tx_data valid
tx_last  in  1  marks final word of burst
tx_ready  out  1  one-cycle pulse when the word is written to spictrl
rx_data  out  32  received word
rx_valid  out  1  rx_data valid, held until rx_ready
rx_last  out  1  qualifies final RX word of burst
rx_ready  in  1  client accepts rx_data
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB write
paddr  out  32  APB address
pwdata  out  32  APB write data
prdata  in  32  APB read data
pready  in  1  APB ready (tie 1 for spictrl)

Behaviour:
- Reset: all outputs 0, FSM IDLE, inflight=0, last_seen=0. Reset mid-transfer drops psel the next edge; no completion of a pending access.
- APB access: SETUP cycle (psel=1, penable=0), then ACCESS (psel=1, penable=1), held until pready=1. prdata is sampled on the ACCESS&pready edge. The next SETUP may follow immediately with no idle gap. paddr/pwrite/pwdata are stable across SETUP+ACCESS.
- States: IDLE, CFG, POLL, TXW, RXR, LST, DRAIN, FIN.
  - IDLE: on start go to CFG, busy=1, err=0.
  - CFG: write MODE_WORD to BASE+0x20, then go to POLL.
  - POLL: read BASE+0x24 into evt. If evt[12] is set, set err. Decision priority:
    1. evt[9] (NE) && !rx_valid && inflight>0 → RXR.
    2. Else if tx_valid && !last_seen && evt[8] (NF) && inflight<MAX_INFLIGHT → TXW.
    3. Else if last_seen && !lst_sent → LST.
    4. Else if last_seen && inflight==0 && !rx_valid → FIN.
    5. Else repoll.
  - TXW: write tx_data to BASE+0x30. At ACCESS completion: tx_ready pulse, inflight+1, last_seen|=tx_last. Return to POLL.
  - RXR: read BASE+0x34 into rx_data, set rx_valid, inflight-1. rx_last=1 iff last_seen && lst_sent && inflight becomes 0. Return to POLL.
  - LST: write 32'h0040_0000 (bit 22) to BASE+0x2C, set lst_sent, then POLL.
  - FIN: done pulse 1 cycle, busy=0, go to IDLE.
- tx_data/tx_last are sampled in the TXW SETUP cycle; the client must hold them until tx_ready.
- rx_valid clears on rx_valid&&rx_ready. While rx_valid=1, no new RX read is issued (backpressure stalls the SPI via inflight).
- inflight counter width is clog2(MAX_INFLIGHT+1). It never wraps: TX is blocked at MAX_INFLIGHT, and RX is never read at 0.
- A start in the same cycle as done is ignored. A start while busy is ignored.
- A zero-length burst is not supported; the first TX word accepted may carry tx_last.

Test Plan:
- start, pready=1 → first APB transfer is a write of 32'h030B_0000 to 0x20 (SETUP then ACCESS, 2 cycles), followed by a read of 0x24.
- Loopback against a spi_wrap slave. One word 32'h0012_3456 with tx_last → write 0x30, write 0x2C=32'h0040_0000, read 0x34; rx_data=32'h0012_3456, rx_valid&rx_last, then done pulse, busy=0.
- 8 random words, pready randomly low 0–3 cycles → 8 tx_ready pulses, 8 RX words in order, inflight never exceeds 8, rx_last only on the 8th.
- rx_ready held low for 500 cycles mid-burst → no further 0x34 reads while rx_valid=1; no TX write once inflight=MAX_INFLIGHT; all data is intact after release.
- Event read returns bit 12 set → err=1, and it stays 1 until the next accepted start clears it.
- rst asserted during a TXW ACCESS cycle → the next cycle has psel=0, busy=0, inflight=0, and no tx_ready pulse. A subsequent start replays CFG.
